pipeline_if: RTL and testbench

Instruction-fetch stage of the five-stage core; sits directly upstream of `pipeline_reg_ifid` and feeds its `inst_in`. Owns the program counter and issues one request at a time to instruction memory over a req/gnt/rvalid handshake. Presents one registered instruction per fetch, holds it while downstream stalls, and squashes in-flight work on a branch/jump redirect from execute.

---
 rtl/pipeline_if_pkg.sv | 19 +
 rtl/pipeline_if.sv | 139 +++++++++++++
 tb/tb_pipeline_if.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_if_pkg.sv
// Shared constants for the instruction-fetch stage.
// Widths, the canonical NOP and the fetch FSM encodings.
package pipeline_if_pkg;

  localparam int          COMMON_WIDTH = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP      = 32'd4;

  localparam logic [1:0] IF_STATE_REQ  = 2'd0;
  localparam logic [1:0] IF_STATE_WAIT = 2'd1;
  localparam logic [1:0] IF_STATE_HOLD = 2'd2;

  function automatic logic [COMMON_WIDTH-1:0] align_word(
    input logic [COMMON_WIDTH-1:0] a
  );
    return {a[COMMON_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_if.sv
// Instruction fetch: owns the PC, one outstanding imem request,
// registered instruction to IF/ID with stall hold and redirect flush.
module pipeline_if
  import pipeline_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_discard;
  logic [31:0] r_hold;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic        r_valid;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_discard_nxt;
  logic [31:0] w_hold_nxt;
  logic        w_deliver;
  logic [31:0] w_deliver_inst;
  logic [31:0] w_pc_inc;

  assign w_pc_inc  = r_pc + PC_STEP;
  assign imem_req  = rst && (r_state == IF_STATE_REQ);
  assign imem_addr = r_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_discard_nxt  = r_discard;
    w_hold_nxt     = r_hold;
    w_deliver      = 1'b0;
    w_deliver_inst = r_hold;
    if (redirect) begin
      w_pc_nxt = align_word(redirect_pc);
      unique case (r_state)
        IF_STATE_REQ: begin
          if (imem_gnt) begin
            w_state_nxt   = IF_STATE_WAIT;
            w_discard_nxt = 1'b1;
          end
        end
        IF_STATE_WAIT: begin
          // response already in flight: either drop it now or mark it stale
          if (imem_rvalid) begin
            w_state_nxt   = IF_STATE_REQ;
            w_discard_nxt = 1'b0;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IF_STATE_REQ;
      endcase
    end else begin
      unique case (r_state)
        IF_STATE_REQ: begin
          if (imem_gnt) w_state_nxt = IF_STATE_WAIT;
        end
        IF_STATE_WAIT: begin
          if (imem_rvalid) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = IF_STATE_REQ;
            end else if (!stall) begin
              w_deliver      = 1'b1;
              w_deliver_inst = imem_rdata;
              w_pc_nxt       = w_pc_inc;
              w_state_nxt    = IF_STATE_REQ;
            end else begin
              w_hold_nxt  = imem_rdata;
              w_state_nxt = IF_STATE_HOLD;
            end
          end
        end
        IF_STATE_HOLD: begin
          if (!stall) begin
            w_deliver   = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = IF_STATE_REQ;
          end
        end
        default: w_state_nxt = IF_STATE_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IF_STATE_REQ;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
      r_hold    <= NOP_INST;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst   <= NOP_INST;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else if (redirect) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (w_deliver) begin
      r_inst   <= w_deliver_inst;
      r_pc_out <= r_pc;
      r_valid  <= 1'b1;
    end else if (!stall) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end
  end

  assign inst_out   = r_inst;
  assign pc_out     = r_pc_out;
  assign inst_valid = r_valid;

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for pipeline_if: fetch, stall/hold, redirect,
// gnt backpressure, PC wrap and asynchronous reset.
module tb_pipeline_if;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        req_a, req_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] inst_a, inst_b;
  logic [31:0] pcout_a, pcout_b;
  logic        valid_a, valid_b;

  int errors;
  int checks;

  pipeline_if dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req_a), .imem_addr(addr_a),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_out(inst_a), .pc_out(pcout_a), .inst_valid(valid_a)
  );

  pipeline_if #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_out(inst_b), .pc_out(pcout_b), .inst_valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;

    step();
    chk("rst_req", {31'd0, req_a}, 32'd0);
    chk("rst_inst", inst_a, NOP);
    chk("rst_pcout", pcout_a, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);

    rst = 1'b1;
    #1;
    chk("first_req", {31'd0, req_a}, 32'd1);
    chk("first_addr", addr_a, 32'h0);
    chk("w_first_addr", addr_b, 32'hFFFF_FFFC);

    // fetch 0x0
    imem_gnt = 1'b1;
    step();
    chk("wait_req", {31'd0, req_a}, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000;
    step();
    chk("f0_valid", {31'd0, valid_a}, 32'd1);
    chk("f0_inst", inst_a, 32'hA000_0000);
    chk("f0_pc", pcout_a, 32'h0);
    chk("f0_next", addr_a, 32'h4);
    chk("w_pc", pcout_b, 32'hFFFF_FFFC);
    chk("w_wrap", addr_b, 32'h0);

    // fetch 0x4
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    step();
    chk("pulse_valid", {31'd0, valid_a}, 32'd0);
    chk("pulse_inst", inst_a, NOP);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0004;
    step();
    chk("f4_inst", inst_a, 32'hA000_0004);
    chk("f4_pc", pcout_a, 32'h4);

    // fetch 0x8
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0008;
    step();
    chk("f8_inst", inst_a, 32'hA000_0008);
    chk("f8_pc", pcout_a, 32'h8);
    chk("f8_next", addr_a, 32'hC);

    // stall across grant, response and hold
    imem_rvalid = 1'b0; imem_gnt = 1'b1; stall = 1'b1;
    step();
    chk("st_frz_valid", {31'd0, valid_a}, 32'd1);
    chk("st_frz_inst", inst_a, 32'hA000_0008);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_000C;
    step();
    chk("st_hold_inst", inst_a, 32'hA000_0008);
    chk("st_hold_pc", pcout_a, 32'h8);
    imem_rvalid = 1'b0;
    step();
    chk("st_hold_req", {31'd0, req_a}, 32'd0);
    chk("st_hold_inst2", inst_a, 32'hA000_0008);
    stall = 1'b0;
    step();
    chk("st_rel_valid", {31'd0, valid_a}, 32'd1);
    chk("st_rel_inst", inst_a, 32'hA000_000C);
    chk("st_rel_pc", pcout_a, 32'hC);
    chk("st_rel_addr", addr_a, 32'h10);
    step();
    chk("st_nodup_valid", {31'd0, valid_a}, 32'd0);
    chk("st_nodup_inst", inst_a, NOP);

    // redirect while waiting
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    chk("rw_valid", {31'd0, valid_a}, 32'd0);
    chk("rw_req", {31'd0, req_a}, 32'd0);
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    step();
    chk("rw_drop_valid", {31'd0, valid_a}, 32'd0);
    chk("rw_drop_inst", inst_a, NOP);
    chk("rw_req2", {31'd0, req_a}, 32'd1);
    chk("rw_addr", addr_a, 32'h100);
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB000_0100;
    step();
    chk("rw_tgt_inst", inst_a, 32'hB000_0100);
    chk("rw_tgt_pc", pcout_a, 32'h100);

    // redirect coinciding with grant
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    chk("rg_valid", {31'd0, valid_a}, 32'd0);
    chk("rg_req", {31'd0, req_a}, 32'd0);
    imem_gnt = 1'b0; redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    step();
    chk("rg_drop_valid", {31'd0, valid_a}, 32'd0);
    chk("rg_addr", addr_a, 32'h200);

    // redirect coinciding with response
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    chk("rr_valid", {31'd0, valid_a}, 32'd0);
    chk("rr_inst", inst_a, NOP);
    chk("rr_req", {31'd0, req_a}, 32'd1);
    chk("rr_addr", addr_a, 32'h300);
    redirect = 1'b0; imem_rvalid = 1'b0;

    // grant withheld
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gw_req", {31'd0, req_a}, 32'd1);
      chk("gw_addr", addr_a, 32'h300);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC000_0300;
    step();
    chk("gw_inst", inst_a, 32'hC000_0300);
    chk("gw_pc", pcout_a, 32'h300);

    // asynchronous reset in WAIT
    imem_rvalid = 1'b0; imem_gnt = 1'b1; stall = 1'b1;
    step();
    chk("ar_pre_valid", {31'd0, valid_a}, 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_inst", inst_a, NOP);
    chk("ar_pc", pcout_a, 32'h0);
    chk("ar_valid", {31'd0, valid_a}, 32'd0);
    chk("ar_req", {31'd0, req_a}, 32'd0);
    imem_gnt = 1'b0; stall = 1'b0;
    step();
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0004;
    #1;
    chk("ar_restart_req", {31'd0, req_a}, 32'd1);
    chk("ar_restart_addr", addr_a, 32'h0);
    chk("w_restart_addr", addr_b, 32'hFFFF_FFFC);
    step();
    imem_rvalid = 1'b0;
    chk("ar_late_valid", {31'd0, valid_a}, 32'd0);
    chk("ar_late_req", {31'd0, req_a}, 32'd1);
    chk("ar_late_addr", addr_a, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
